// File: rtl/dsp_console_if.sv
// dsp_console_if: byte stream in, display-cell writes out.
//   in_data/in_attr/in_valid : character byte plus attribute, offered by the producer
//   in_ready                 : console can take a byte this cycle
//   addr                     : cell address {row[4:0], col[6:0]}
//   wr                       : one-cycle write strobe
//   data_out                 : {attribute, character}
// master = producer / display side, slave = console.
interface dsp_console_if;
  logic [7:0]  in_data;
  logic [7:0]  in_attr;
  logic        in_valid;
  logic        in_ready;
  logic [13:2] addr;
  logic        wr;
  logic [15:0] data_out;

  modport master (output in_data, in_attr, in_valid,
                  input  in_ready, addr, wr, data_out);
  modport slave  (input  in_data, in_attr, in_valid,
                  output in_ready, addr, wr, data_out);
endinterface

// File: rtl/dsp_console.sv
// dsp_console: text console front end. Takes character bytes and turns them
// into registered writes into a ROWS x COLS cell display, handling CR, LF,
// BS and FF, and blanking rows on scroll and the whole screen on FF/reset.
//   clk   : single clock, rising edge
//   reset : asynchronous, active low
//   bus   : dsp_console_if.slave (byte stream in, cell writes out)
module dsp_console #(
  parameter int          ROWS     = 30,
  parameter int          COLS     = 80,
  parameter logic [7:0]  CLR_ATTR = 8'h07
) (
  input  logic         clk,
  input  logic         reset,
  dsp_console_if.slave bus
);

  localparam logic [1:0] S_CLEAR_ALL = 2'd0;
  localparam logic [1:0] S_IDLE      = 2'd1;
  localparam logic [1:0] S_CLEAR_ROW = 2'd2;

  localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
  localparam logic [15:0] BLANK    = {CLR_ATTR, 8'h20};

  logic [1:0] state;
  logic [4:0] row, clr_row, next_row;
  logic [6:0] col, clr_col;
  logic       accept;

  assign bus.in_ready = (state == S_IDLE);
  assign accept       = bus.in_valid && bus.in_ready;
  assign next_row     = (row == LAST_ROW) ? 5'd0 : row + 5'd1;

  // clr_col always returns to 0 when a clear pass finishes, so CLEAR_ROW
  // can start directly from it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_CLEAR_ALL;
      row          <= '0;
      col          <= '0;
      clr_row      <= '0;
      clr_col      <= '0;
      bus.wr       <= 1'b0;
      bus.addr     <= '0;
      bus.data_out <= '0;
    end else begin
      bus.wr <= 1'b0;
      case (state)
        S_CLEAR_ALL: begin
          bus.wr       <= 1'b1;
          bus.addr     <= {clr_row, clr_col};
          bus.data_out <= BLANK;
          if (clr_col == LAST_COL) begin
            clr_col <= '0;
            if (clr_row == LAST_ROW) begin
              clr_row <= '0;
              state   <= S_IDLE;
            end else begin
              clr_row <= clr_row + 5'd1;
            end
          end else begin
            clr_col <= clr_col + 7'd1;
          end
        end

        S_CLEAR_ROW: begin
          bus.wr       <= 1'b1;
          bus.addr     <= {row, clr_col};
          bus.data_out <= BLANK;
          if (clr_col == LAST_COL) begin
            clr_col <= '0;
            state   <= S_IDLE;
          end else begin
            clr_col <= clr_col + 7'd1;
          end
        end

        S_IDLE: begin
          if (accept) begin
            if (bus.in_data >= 8'h20) begin
              // Character write goes out now; a wrap-induced row clear
              // starts on the following cycle.
              bus.wr       <= 1'b1;
              bus.addr     <= {row, col};
              bus.data_out <= {bus.in_attr, bus.in_data};
              if (col == LAST_COL) begin
                col   <= '0;
                row   <= next_row;
                state <= S_CLEAR_ROW;
              end else begin
                col <= col + 7'd1;
              end
            end else begin
              case (bus.in_data)
                8'h0D: col <= '0;
                8'h08: if (col != 7'd0) col <= col - 7'd1;
                8'h0A: begin
                  col   <= '0;
                  row   <= next_row;
                  state <= S_CLEAR_ROW;
                end
                8'h0C: begin
                  row     <= '0;
                  col     <= '0;
                  clr_row <= '0;
                  clr_col <= '0;
                  state   <= S_CLEAR_ALL;
                end
                default: ;  // other control codes are swallowed
              endcase
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_console.sv
module tb_dsp_console;
  localparam int ROWS = 30;
  localparam int COLS = 80;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dsp_console_if bus();

  dsp_console #(.ROWS(ROWS), .COLS(COLS), .CLR_ATTR(8'h07)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: queue of per-cycle expected outputs. v=0 entries are
  // cycles where the console is busy but writes nothing.
  typedef struct {
    bit          v;
    logic [11:0] a;
    logic [15:0] d;
  } ent_t;

  ent_t        q[$];
  int          mr, mc;
  logic [11:0] last_a;
  logic [15:0] last_d;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk(input bit v, input int r, input int c, input logic [15:0] d);
    ent_t e;
    e.v = v;
    e.a = 12'(r * 128 + c);
    e.d = d;
    return e;
  endfunction

  task automatic push_row_clear(input int r);
    for (int c = 0; c < COLS; c++) q.push_back(mk(1'b1, r, c, 16'h0720));
  endtask

  task automatic push_screen_clear();
    for (int r = 0; r < ROWS; r++) push_row_clear(r);
  endtask

  task automatic adv_row();
    mr = (mr == ROWS - 1) ? 0 : mr + 1;
  endtask

  task automatic model_byte(input logic [7:0] d, input logic [7:0] a);
    if (d >= 8'h20) begin
      q.push_back(mk(1'b1, mr, mc, {a, d}));
      if (mc == COLS - 1) begin
        mc = 0;
        adv_row();
        push_row_clear(mr);
      end else mc++;
    end else begin
      case (d)
        8'h0D: mc = 0;
        8'h08: if (mc > 0) mc--;
        8'h0A: begin
          mc = 0;
          adv_row();
          q.push_back(mk(1'b0, 0, 0, 16'h0));
          push_row_clear(mr);
        end
        8'h0C: begin
          mr = 0;
          mc = 0;
          q.push_back(mk(1'b0, 0, 0, 16'h0));
          push_screen_clear();
        end
        default: ;
      endcase
    end
  endtask

  // One clock: drive inputs, take the edge, check outputs #1 later.
  task automatic cyc(input logic v, input logic [7:0] d, input logic [7:0] a);
    logic acc;
    ent_t e;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_attr  = a;
    acc = v && (q.size() == 0);
    @(posedge clk);
    if (acc) model_byte(d, a);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.v) begin
        last_a = e.a;
        last_d = e.d;
      end
      chk("wr", bus.wr, e.v);
    end else begin
      chk("wr", bus.wr, 0);
    end
    chk("addr", bus.addr, last_a);
    chk("data_out", bus.data_out, last_d);
    chk("in_ready", bus.in_ready, q.size() == 0);
  endtask

  task automatic drain();
    while (q.size() > 0) cyc(1'b1, 8'($urandom), 8'($urandom));
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    #1;
    q.delete();
    mr = 0;
    mc = 0;
    last_a = '0;
    last_d = '0;
    chk("rst_wr", bus.wr, 0);
    chk("rst_addr", bus.addr, 0);
    chk("rst_data", bus.data_out, 0);
    chk("rst_ready", bus.in_ready, 0);
    repeat (cycles) @(posedge clk);
    #1;
    chk("rst_hold_wr", bus.wr, 0);
    chk("rst_hold_ready", bus.in_ready, 0);
    @(negedge clk);
    reset = 1'b1;
    push_screen_clear();
  endtask

  task automatic run_init();
    int n;
    cyc(1'b0, 8'h00, 8'h00);
    chk("init_first_addr", bus.addr, 0);
    chk("init_first_data", bus.data_out, 16'h0720);
    n = int'(bus.wr);
    while (q.size() > 0) begin
      cyc(1'b0, 8'h00, 8'h00);
      n += int'(bus.wr);
    end
    chk("init_len", n, 2400);
    chk("init_ready", bus.in_ready, 1);
  endtask

  initial begin
    logic [7:0] b;
    int         r;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_attr  = 8'h00;
    #2;

    do_reset(3);
    run_init();

    // 'A' at home
    cyc(1'b1, 8'h41, 8'h1E);
    chk("A_wr", bus.wr, 1);
    chk("A_addr", bus.addr, 12'h000);
    chk("A_data", bus.data_out, 16'h1E41);

    // fill to (0,79), then 'Z' wraps and clears row 1
    for (int i = 0; i < 78; i++) cyc(1'b1, 8'h61, 8'h07);
    cyc(1'b1, 8'h5A, 8'h07);
    chk("Z_addr", bus.addr, 12'd79);
    chk("Z_data", bus.data_out, 16'h075A);
    cyc(1'b0, 8'h00, 8'h00);
    chk("Z_clr0_addr", bus.addr, 12'd128);
    chk("Z_clr0_ready", bus.in_ready, 0);
    drain();
    cyc(1'b1, 8'h51, 8'h07);
    chk("Z_cursor", bus.addr, 12'd128);

    // down to row 29, col 10; LF then wraps to row 0
    for (int i = 0; i < 28; i++) begin
      cyc(1'b1, 8'h0A, 8'h00);
      drain();
    end
    cyc(1'b1, 8'h0D, 8'h00);
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'h30, 8'h07);
    cyc(1'b1, 8'h0A, 8'h00);
    chk("LF_nowr", bus.wr, 0);
    cyc(1'b0, 8'h00, 8'h00);
    chk("LF_clr_addr", bus.addr, 12'd0);
    chk("LF_clr_data", bus.data_out, 16'h0720);
    drain();
    cyc(1'b1, 8'h42, 8'h07);
    chk("LF_cursor", bus.addr, 12'd0);

    // to (3,0); BS, CR, BEL do nothing visible
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 8'h0A, 8'h00);
      drain();
    end
    cyc(1'b1, 8'h08, 8'h00);
    chk("BS_nowr", bus.wr, 0);
    cyc(1'b1, 8'h0D, 8'h00);
    chk("CR_nowr", bus.wr, 0);
    cyc(1'b1, 8'h07, 8'h00);
    chk("BEL_nowr", bus.wr, 0);
    cyc(1'b1, 8'h43, 8'h07);
    chk("ctl_cursor", bus.addr, 12'd384);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 299);
      if (r == 0)       b = 8'h0C;
      else if (r < 12)  b = 8'h0A;
      else if (r < 24)  b = 8'h0D;
      else if (r < 36)  b = 8'h08;
      else if (r < 48)  b = 8'($urandom_range(0, 31));
      else              b = 8'($urandom_range(32, 255));
      cyc($urandom_range(0, 3) != 0, b, 8'($urandom));
    end
    drain();

    // form feed
    cyc(1'b1, 8'h0C, 8'h00);
    chk("FF_nowr", bus.wr, 0);
    drain();
    cyc(1'b1, 8'h46, 8'h07);
    chk("FF_cursor", bus.addr, 12'd0);

    // reset in the middle of the screen clear
    do_reset(2);
    for (int i = 0; i < 500; i++) cyc(1'b0, 8'h00, 8'h00);
    chk("mid_wr_before", bus.wr, 1);
    do_reset(2);
    run_init();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dsp_console.md
DSP_CONSOLE -- requirements
Module: dsp_console

Interface
REQ-001 SHALL have parameter ROWS, default 30, number of text rows (1..32).
REQ-002 SHALL have parameter COLS, default 80, number of text columns (1..128).
REQ-003 SHALL have parameter CLR_ATTR, default 8'h07, attribute byte used for cleared cells.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_data  input  8  character code.
REQ-007 SHALL have port in_attr  input  8  attribute for in_data.
REQ-008 SHALL have port in_valid  input  1  in_data/in_attr valid.
REQ-009 SHALL have port in_ready  output  1  console accepts a byte this cycle.
REQ-010 SHALL have port addr  output  12 (bits [13:2])  display cell address, {row[4:0], col[6:0]}.
REQ-011 SHALL have port wr  output  1  single-cycle display write strobe.
REQ-012 SHALL have port data_out  output  16  {attribute[15:8], character[7:0]}.

Function
REQ-013 SHALL register addr, wr and data_out; in_ready SHALL be combinational from state (high only in IDLE).
REQ-014 SHALL accept a byte on a rising edge where in_valid and in_ready are both 1.
REQ-015 SHALL hold an internal cursor (row 0..ROWS-1, col 0..COLS-1).
REQ-016 SHALL implement states CLEAR_ALL, IDLE and CLEAR_ROW.
REQ-017 For an accepted byte >= 0x20: SHALL present wr=1, addr={row,col}, data_out={in_attr,in_data} in the cycle after acceptance (latency 1), then advance col.
REQ-018 When col advances past COLS-1: col SHALL become 0 and the row SHALL advance (REQ-021).
REQ-019 0x0D SHALL set col=0 with no write; 0x08 SHALL decrement col if col>0, else no change, with no write.
REQ-020 0x0A SHALL set col=0 and advance the row (REQ-021) with no write of the byte itself.
REQ-021 Row advance: row SHALL become row+1, or 0 when row=ROWS-1; the state SHALL then go to CLEAR_ROW for the new row.
REQ-022 CLEAR_ROW SHALL write {CLR_ATTR,8'h20} to cols 0..COLS-1 of the current row, one per cycle, consecutive, wr=1 each cycle; then return to IDLE.
REQ-023 When the advance is caused by a printable byte, that byte's write SHALL be issued first; the first CLEAR_ROW write SHALL follow in the next cycle.
REQ-024 0x0C SHALL home the cursor (0,0) and enter CLEAR_ALL.
REQ-025 CLEAR_ALL SHALL write {CLR_ATTR,8'h20} to all ROWS*COLS cells row-major from (0,0), one per cycle, consecutive; then IDLE with cursor (0,0).
REQ-026 in_ready SHALL be 1 in the same cycle that the last write of CLEAR_ROW/CLEAR_ALL is on the outputs.
REQ-027 Other codes < 0x20 SHALL be accepted and discarded with no write and no cursor change.
REQ-028 wr SHALL be 0 in every cycle not defined above; when wr=0 addr/data_out hold their last values.
REQ-029 Bytes presented while in_ready=0 SHALL NOT be consumed; in_data/in_attr SHALL be sampled only at acceptance.

Reset
REQ-030 While reset=0: wr=0, addr=0, data_out=0, cursor (0,0), state CLEAR_ALL, in_ready=0.
REQ-031 On the first rising edge after reset deasserts, the first CLEAR_ALL write (cell (0,0)) SHALL be presented.
REQ-032 Reset asserted mid-operation SHALL abort it immediately; after release the full CLEAR_ALL SHALL restart from (0,0).

Verification
REQ-033 Reset release, defaults -> wr high exactly 2400 consecutive cycles, addrs row-major (0,0)..(29,79), data_out=16'h0720, then in_ready=1.
REQ-034 After init, send 'A' attr 8'h1E -> next cycle wr=1, addr={5'd0,7'd0}, data_out=16'h1E41; cursor (0,1).
REQ-035 Cursor (0,79), send 'Z' attr 8'h07 -> write at (0,79) data 16'h075A, then 80 clears of row 1, in_ready=0 throughout, cursor (1,0).
REQ-036 Cursor (29,10), send 0x0A -> no char write; 80 clears of row 0; cursor (0,0).
REQ-037 Cursor (3,0), send 0x08 then 0x0D then 0x07 -> no writes, cursor stays (3,0), each byte accepted in one cycle.
REQ-038 Reset pulsed after 500 CLEAR_ALL writes -> wr drops immediately; after release CLEAR_ALL restarts at (0,0), 2400 writes.
